// File: rtl/andor_arbiter.sv
// andor_arbiter: four-requester arbiter and sequencer for one shared
// AND-OR evaluation unit (y = a&b | c&d, bitwise over W bits).
// A winner's operands are latched on the granting edge. The shared unit
// is evaluated in the following cycle. The result comes back registered
// and tagged with the winner's index.
// Optional feature macro: ANDOR_RR_EN.
//   Defined   -> round-robin arbitration, starting after the last grant.
//   Undefined -> fixed priority, requester 0 highest and 3 lowest.
module andor_arbiter #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] a,
    input  logic [4*W-1:0] b,
    input  logic [4*W-1:0] c,
    input  logic [4*W-1:0] d,
    output logic [3:0]     gnt,
    output logic [W-1:0]   y,
    output logic           valid,
    output logic [1:0]     id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [3:0]   gnt_next;
    logic [W-1:0] y_next;
    logic         valid_next;
    logic [1:0]   id_next;
    logic         busy_next;

    // Operands of the current winner, frozen on the granting edge
    logic [W-1:0] op_a, op_b, op_c, op_d;
    logic [W-1:0] op_a_next, op_b_next, op_c_next, op_d_next;

    // Index of the requester that owns the operation in flight
    logic [1:0]   winner, winner_next;

    // Arbitration result for the current req vector
    logic         pick_valid;
    logic [1:0]   pick_idx;

    // The single shared AND-OR evaluation, fed only from latched operands
    logic [W-1:0] andor_out;

`ifdef ANDOR_RR_EN
    // Most recently granted requester; the search starts just after it
    logic [1:0]   last_grant, last_grant_next;

    // Round-robin search from last_grant+1, wrapping 3 -> 0
    always_comb begin
        logic [1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end
`else
    // Fixed priority: the lowest-numbered active requester wins
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(k);
            end
        end
    end
`endif

    // Shared AND-OR datapath instance
    always_comb begin
        andor_out = (op_a & op_b) | (op_c & op_d);
    end

    // Next-state and next-output logic; every register holds unless its state changes it
    always_comb begin
        state_next  = state;
        gnt_next    = gnt;
        y_next      = y;
        valid_next  = valid;
        id_next     = id;
        op_a_next   = op_a;
        op_b_next   = op_b;
        op_c_next   = op_c;
        op_d_next   = op_d;
        winner_next = winner;
`ifdef ANDOR_RR_EN
        last_grant_next = last_grant;
`endif
        case (state)
            IDLE: begin
                valid_next = 1'b0;
                gnt_next   = 4'b0000;
                if (pick_valid) begin
                    op_a_next   = a[pick_idx*W +: W];
                    op_b_next   = b[pick_idx*W +: W];
                    op_c_next   = c[pick_idx*W +: W];
                    op_d_next   = d[pick_idx*W +: W];
                    gnt_next    = 4'b0001 << pick_idx;
                    winner_next = pick_idx;
`ifdef ANDOR_RR_EN
                    last_grant_next = pick_idx;
`endif
                    state_next  = EVAL;
                end
            end
            EVAL: begin
                y_next     = andor_out;
                id_next    = winner;
                valid_next = 1'b1;
                gnt_next   = 4'b0000;
                state_next = RESP;
            end
            RESP: begin
                valid_next = 1'b0;
                gnt_next   = 4'b0000;
                state_next = IDLE;
            end
            default: begin
                valid_next = 1'b0;
                gnt_next   = 4'b0000;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= 4'b0000;
            y      <= '0;
            valid  <= 1'b0;
            id     <= 2'd0;
            busy   <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_c   <= '0;
            op_d   <= '0;
            winner <= 2'd0;
`ifdef ANDOR_RR_EN
            last_grant <= 2'd3;
`endif
        end else begin
            state  <= state_next;
            gnt    <= gnt_next;
            y      <= y_next;
            valid  <= valid_next;
            id     <= id_next;
            busy   <= busy_next;
            op_a   <= op_a_next;
            op_b   <= op_b_next;
            op_c   <= op_c_next;
            op_d   <= op_d_next;
            winner <= winner_next;
`ifdef ANDOR_RR_EN
            last_grant <= last_grant_next;
`endif
        end
    end

endmodule

// File: tb/tb_andor_arbiter.sv
// tb_andor_arbiter: directed-vector bench for andor_arbiter with W=1.
// Expected grants follow the arbitration mode chosen by ANDOR_RR_EN.
module tb_andor_arbiter;

    localparam int W = 1;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] a, b, c, d;
    logic [3:0]     gnt;
    logic [W-1:0]   y;
    logic           valid;
    logic [1:0]     id;
    logic           busy;

    int errors = 0;
    int checks = 0;

    andor_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .y     (y),
        .valid (valid),
        .id    (id),
        .busy  (busy)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive request and operand inputs
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] va,
                                 input logic [3:0] vb, input logic [3:0] vc,
                                 input logic [3:0] vd);
        req = r;
        a   = va;
        b   = vb;
        c   = vc;
        d   = vd;
    endtask

    // Advance one cycle and settle just past the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE: T (sample), T+1 (gnt), T+2 (valid), T+3 (idle)
    task automatic doOp(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                        input logic exp_y, input logic [1:0] exp_id, input bit hold);
        req = r;
        tick();
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        checkOutput({tag, "_busy1"}, 32'(busy), 32'd1);
        checkOutput({tag, "_valid_early"}, 32'(valid), 32'd0);
        if (!hold) req = 4'b0000;
        tick();
        checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
        checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
        checkOutput({tag, "_id"}, 32'(id), 32'(exp_id));
        checkOutput({tag, "_gnt_off"}, 32'(gnt), 32'd0);
        tick();
        checkOutput({tag, "_valid_off"}, 32'(valid), 32'd0);
        checkOutput({tag, "_busy0"}, 32'(busy), 32'd0);
        checkOutput({tag, "_y_hold"}, 32'(y), 32'(exp_y));
    endtask

    initial begin
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

        // Reset held two cycles with all requests active
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_gnt", 32'(gnt), 32'd0);
            checkOutput("rst_valid", 32'(valid), 32'd0);
            checkOutput("rst_y", 32'(y), 32'd0);
            checkOutput("rst_id", 32'(id), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        doOp("first", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0);

        // Single request from requester 2: 1&1 | 0&0 = 1
        applyStimulus(4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        doOp("single2", 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);

        // Requester 1: 1&0 | 1&0 = 0, then 1&0 | 1&1 = 1
        applyStimulus(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
        doOp("res0", 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
        applyStimulus(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
        doOp("res1", 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);

        // Fairness under continuous requests, starting from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
`ifdef ANDOR_RR_EN
        doOp("rr0", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1);
        doOp("rr1", 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b1);
        doOp("rr2", 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b1);
        doOp("rr3", 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b1);
        doOp("rr4", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1);
        doOp("p1010a", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        doOp("p1010b", 4'b1010, 4'b1000, 1'b1, 2'd3, 1'b1);
        doOp("p1010c", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
`else
        doOp("fp0", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1);
        doOp("fp1", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1);
        doOp("p1010a", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        doOp("p1010b", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        doOp("p1010c", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
`endif
        doOp("p1000", 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1);

        // Operands change right after the grant; y must use the captured values
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick();
        checkOutput("stab_gnt", 32'(gnt), 32'b0001);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        checkOutput("stab_valid", 32'(valid), 32'd1);
        checkOutput("stab_y", 32'(y), 32'd1);
        checkOutput("stab_id", 32'(id), 32'd0);
        tick();

        // Reset during EVAL aborts the operation with no valid pulse
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        checkOutput("abort_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_valid", 32'(valid), 32'd0);
        checkOutput("abort_gnt_clr", 32'(gnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_id", 32'(id), 32'd0);
        checkOutput("abort_y", 32'(y), 32'd0);
        applyStimulus(4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        doOp("post_abort", 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
